// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states and the command/response widths used by both link ends.
package spi_pkg;

  localparam int SPI_CMD_WIDTH = 56;
  localparam int SPI_RSP_WIDTH = 48;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_master_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter that saturates at zero; tc is high while the count is zero.
module spi_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/sync_sig.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_sig (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/spi_master_iff.sv
// SPI mode-0 master, one fixed-length frame per start request.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to add the loopback port (internal MOSI->RX).
module spi_master_iff
  import spi_pkg::*;
#(
  parameter int TX_WIDTH = SPI_CMD_WIDTH,
  parameter int RX_WIDTH = SPI_RSP_WIDTH,
  parameter int CLK_DIV  = 8,
  parameter int SS_SETUP = 8,
  parameter int SS_HOLD  = 8,
  parameter int SS_GAP   = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic [TX_WIDTH-1:0] tx_data,
  output logic                busy,
  output logic                done,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                spi_clk,
  output logic                spi_ss,
  output logic                spi_mosi,
  input  logic                spi_miso
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic                loopback
`endif
);

  localparam int PH_W = $clog2(max4(CLK_DIV, SS_SETUP, SS_HOLD, SS_GAP));
  localparam int BC_W = $clog2(TX_WIDTH + 1);
  localparam int RC_W = $clog2(RX_WIDTH + 1);

  if (TX_WIDTH < 2) begin : g_chk_tx
    $error("TX_WIDTH must be >= 2");
  end
  if (RX_WIDTH < 1 || RX_WIDTH > TX_WIDTH) begin : g_chk_rx
    $error("RX_WIDTH must be in 1..TX_WIDTH");
  end
  if (CLK_DIV < 8) begin : g_chk_div
    $error("CLK_DIV must be >= 8");
  end
  if (SS_SETUP < 4) begin : g_chk_setup
    $error("SS_SETUP must be >= 4");
  end
  if (SS_HOLD < 1) begin : g_chk_hold
    $error("SS_HOLD must be >= 1");
  end
  if (SS_GAP < 4) begin : g_chk_gap
    $error("SS_GAP must be >= 4");
  end

  spi_master_state_t state_reg, state_next;

  logic                tc;
  logic                load;
  logic [PH_W-1:0]     load_value;
  logic                accept, rise, fall, last_fall, finish;
  logic                lb_in, lb_reg, lb_next;
  logic                spi_clk_next, spi_ss_next, busy_next;
  logic                miso_sync, rx_bit;
  logic                spi_clk_reg, spi_ss_reg, mosi_reg, busy_reg, done_reg;
  logic [TX_WIDTH-1:0] tx_shift_reg;
  logic [RX_WIDTH-1:0] rx_shift_reg, rx_data_reg;
  logic [BC_W-1:0]     bit_cnt_reg;
  logic [RC_W-1:0]     rx_cnt_reg;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_in = loopback;
`else
  assign lb_in = 1'b0;
`endif

  sync_sig u_miso_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (spi_miso),
    .q    (miso_sync)
  );

  spi_phase_timer #(.WIDTH(PH_W)) u_timer (
    .clk        (clk),
    .nrst       (nrst),
    .load       (load),
    .load_value (load_value),
    .tc         (tc)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Each phase loads the timer with duration-1 on entry and leaves when it reaches zero.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_value = '0;
    accept     = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    last_fall  = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        state_next = SETUP;
        load       = 1'b1;
        load_value = PH_W'(SS_SETUP - 1);
        accept     = 1'b1;
      end
      SETUP, LOW: if (tc) begin
        state_next = HIGH;
        load       = 1'b1;
        load_value = PH_W'(CLK_DIV - 1);
        rise       = 1'b1;
      end
      HIGH: if (tc) begin
        load = 1'b1;
        if (bit_cnt_reg == BC_W'(TX_WIDTH)) begin
          state_next = HOLD;
          load_value = PH_W'(SS_HOLD - 1);
          last_fall  = 1'b1;
        end else begin
          state_next = LOW;
          load_value = PH_W'(CLK_DIV - 1);
          fall       = 1'b1;
        end
      end
      HOLD: if (tc) begin
        state_next = GAP;
        load       = 1'b1;
        load_value = PH_W'(SS_GAP - 1);
        finish     = 1'b1;
      end
      GAP: if (tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    lb_next      = accept ? lb_in : lb_reg;
    busy_next    = (state_next != IDLE);
    spi_clk_next = (state_next == HIGH) && !lb_next;
    spi_ss_next  = lb_next || !(state_next inside {SETUP, HIGH, LOW, HOLD});
  end

  // In loopback the bit on internal MOSI at the rising-edge cycle is the one the slave would see.
  assign rx_bit = lb_reg ? mosi_reg : miso_sync;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      spi_clk_reg  <= 1'b0;
      spi_ss_reg   <= 1'b1;
      mosi_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      lb_reg       <= 1'b0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      rx_cnt_reg   <= '0;
    end else begin
      spi_clk_reg <= spi_clk_next;
      spi_ss_reg  <= spi_ss_next;
      busy_reg    <= busy_next;
      done_reg    <= finish;
      lb_reg      <= lb_next;
      if (accept) begin
        tx_shift_reg <= tx_data;
        mosi_reg     <= tx_data[TX_WIDTH-1];
        bit_cnt_reg  <= '0;
        rx_cnt_reg   <= '0;
        rx_shift_reg <= '0;
      end
      if (rise) begin
        if (bit_cnt_reg != BC_W'(TX_WIDTH)) bit_cnt_reg <= bit_cnt_reg + BC_W'(1);
        if (rx_cnt_reg != RC_W'(RX_WIDTH)) begin
          rx_shift_reg <= (rx_shift_reg << 1) | RX_WIDTH'(rx_bit);
          rx_cnt_reg   <= rx_cnt_reg + RC_W'(1);
        end
      end
      if (fall) begin
        tx_shift_reg <= tx_shift_reg << 1;
        mosi_reg     <= tx_shift_reg[TX_WIDTH-2];
      end
      if (last_fall) mosi_reg <= 1'b0;
      if (finish)    rx_data_reg <= rx_shift_reg;
    end
  end

  assign spi_clk  = spi_clk_reg;
  assign spi_ss   = spi_ss_reg;
  assign spi_mosi = mosi_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rx_data  = rx_data_reg;

endmodule
